mem_access_ctrl: RTL



---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_lane_merge.sv | 51 +++++
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory access controller: request sizes, FSM states,
// lane widths/masks and the misalignment rule.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  localparam int          BYTE_W    = 8;
  localparam int          HALF_W    = 16;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  // Size 2'b11 behaves as a word.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    if (size == SZ_BYTE) return 1'b0;
    if (size == SZ_HALF) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane logic: extract+extend a byte/half/word for loads and
// insert a byte/half into a word for sub-word stores.
// Ports: i_word (memory word), i_size, i_off (addr[1:0]), i_unsigned,
//        i_wdata (right-justified store data), o_load, o_merge.
module mem_lane_merge
  import mem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [1:0]       i_size,
  input  logic [1:0]       i_off,
  input  logic             i_unsigned,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_load,
  output logic [WIDTH-1:0] o_merge
);

  logic [1:0]       w_blane;
  logic             w_hlane;
  logic [4:0]       w_sh;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_lane;

  always_comb begin
    // Big-endian: offset 0 is the most significant lane.
    w_blane = BIG_ENDIAN ? ~i_off : i_off;
    w_hlane = BIG_ENDIAN ? ~i_off[1] : i_off[1];
    w_sh    = 5'd0;
    w_mask  = '1;
    if (i_size == SZ_BYTE) begin
      w_sh   = {w_blane, 3'b000};
      w_mask = BYTE_MASK;
    end else if (i_size == SZ_HALF) begin
      w_sh   = {w_hlane, 4'b0000};
      w_mask = HALF_MASK;
    end
    w_lane = (i_word >> w_sh) & w_mask;
    o_load = w_lane;
    if (!i_unsigned && i_size == SZ_BYTE)
      o_load = {{(WIDTH-BYTE_W){w_lane[BYTE_W-1]}},
                w_lane[BYTE_W-1:0]};
    else if (!i_unsigned && i_size == SZ_HALF)
      o_load = {{(WIDTH-HALF_W){w_lane[HALF_W-1]}},
                w_lane[HALF_W-1:0]};
    o_merge = (i_word & ~(w_mask << w_sh))
            | ((i_wdata & w_mask) << w_sh);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Processor-side initiator for a word-only memory: loads with extension,
// sub-word stores via read-modify-write. Optional MEM_ACCESS_MISALIGN_TRAP_EN
// flags misaligned half/word requests with resp_err and skips memory.
// Ports: clk/rst (sync, active high); req_* request channel with
// req_ready; resp_valid/resp_rdata/resp_err; mem_we/mem_addr/mem_wr_data
// out and mem_rd_data (combinational read) in.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  input  logic [WIDTH-1:0] mem_rd_data
);

  state_e           r_state;
  state_e           w_next;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_merge;
  logic [WIDTH-1:0] r_rdata;
  logic             w_acc;
  logic             w_mis;
  logic             w_req_word;
  logic             w_lat_word;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_merge;

  assign w_acc      = req_valid & req_ready;
  assign w_req_word = (req_size != SZ_BYTE) && (req_size != SZ_HALF);
  assign w_lat_word = (r_size != SZ_BYTE) && (r_size != SZ_HALF);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic r_err;

  assign w_mis    = misaligned(req_size, req_addr[1:0]);
  assign resp_err = r_err;

  always_ff @(posedge clk) begin
    if (rst)        r_err <= 1'b0;
    else if (w_acc) r_err <= w_mis;
  end
`else
  assign w_mis    = 1'b0;
  assign resp_err = 1'b0;
`endif

  mem_lane_merge #(
    .WIDTH      (WIDTH),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane (
    .i_word     (mem_rd_data),
    .i_size     (r_size),
    .i_off      (r_addr[1:0]),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_mis)       w_next = ST_RESP;
          else if (!req_we)    w_next = ST_LOAD;
          else if (w_req_word) w_next = ST_WRITE;
          else                 w_next = ST_RMW_RD;
        end
      end
      ST_LOAD:   w_next = ST_RESP;
      ST_RMW_RD: w_next = ST_WRITE;
      ST_WRITE:  w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (r_state == ST_IDLE);
    resp_valid  = (r_state == ST_RESP);
    // No write may land on an edge where reset is asserted.
    mem_we      = (r_state == ST_WRITE) & ~rst;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (r_state != ST_IDLE)
      mem_addr = {r_addr[WIDTH-1:2], 2'b00};
    if (r_state == ST_WRITE)
      mem_wr_data = w_lat_word ? r_wdata : r_merge;
  end

  assign resp_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_merge <= '0;
      r_rdata <= '0;
    end else begin
      if (w_acc) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        // Stores and trapped requests report zero data.
        r_rdata <= '0;
      end
      if (r_state == ST_LOAD && !r_we)
        r_rdata <= w_load;
      if (r_state == ST_RMW_RD)
        r_merge <= w_merge;
    end
  end

endmodule
